// File: rtl/fb_write_queue.sv
// Host-to-framebuffer write queue: buffers host writes and replays them one word per cycle,
// with a fill command at address 0x7FFF. Define FBQ_VBLANK_ONLY_EN to drain only during vblank.
module fb_write_queue #(
  parameter int DEPTH    = 16,
  parameter int FB_WORDS = 9600
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [14:0] address,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  input  logic        vblank,
  output logic [14:0] fb_address,
  output logic [31:0] fb_writedata,
  output logic        fb_write,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [14:0] FB_LIMIT = 15'(FB_WORDS);
  localparam logic [14:0] FB_LAST  = 15'(FB_WORDS - 1);
  localparam logic [14:0] FILL_CMD = 15'h7FFF;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state, state_d;

  // Entry layout: {is_fill, address, data}
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [47:0]   head;
  logic [14:0]   fill_addr;
  logic [31:0]   pattern;
  logic          empty, gate, accept, push, pop, head_fill, is_fill_cmd;

  assign empty       = (count == '0);
  assign waitrequest = (count == FULL_CNT);
  assign accept      = chipselect & write & ~waitrequest;
  assign is_fill_cmd = (address == FILL_CMD);
  assign push        = accept & ((address < FB_LIMIT) | is_fill_cmd);
  assign head        = mem[rd_ptr];
  assign head_fill   = head[47];
  assign busy        = ~empty | (state == FILL) | fb_write;
  assign dbg_state   = state;

`ifdef FBQ_VBLANK_ONLY_EN
  assign gate = vblank;
`else
  assign gate = 1'b1;
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  // IDLE pops too, so a write into an empty queue reaches fb_write one cycle after acceptance.
  assign pop = (state != FILL) & gate & ~empty;

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DRAIN: begin
        if (pop) state_d = head_fill ? FILL : DRAIN;
        else     state_d = IDLE;
      end
      FILL: begin
        if (gate && fill_addr == FB_LAST) state_d = empty ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr] <= {is_fill_cmd, address, writedata};
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // fb_address/fb_writedata only change alongside a write strobe, so they hold otherwise.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      fb_write     <= 1'b0;
      fb_address   <= '0;
      fb_writedata <= '0;
      fill_addr    <= '0;
      pattern      <= '0;
    end else begin
      fb_write <= 1'b0;
      if (pop && !head_fill) begin
        fb_write     <= 1'b1;
        fb_address   <= head[46:32];
        fb_writedata <= head[31:0];
      end
      if (pop && head_fill) begin
        pattern   <= head[31:0];
        fill_addr <= '0;
      end
      if (state == FILL && gate) begin
        fb_write     <= 1'b1;
        fb_address   <= fill_addr;
        fb_writedata <= pattern;
        fill_addr    <= (fill_addr == FB_LAST) ? 15'd0 : fill_addr + 15'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_queue.sv
// Scoreboard bench for fb_write_queue: host writes expand into expected framebuffer writes,
// a negedge monitor pops and compares each fb_write.
module tb_fb_write_queue;

  localparam int DEPTH    = 16;
  localparam int FB_WORDS = 9600;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        chipselect, write, vblank;
  logic [14:0] address;
  logic [31:0] writedata;
  logic        waitrequest, fb_write, busy;
  logic [14:0] fb_address;
  logic [31:0] fb_writedata;
  logic [1:0]  dbg_state;

  logic [46:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int n_writes   = 0;

  fb_write_queue #(.DEPTH(DEPTH), .FB_WORDS(FB_WORDS)) dut (
    .clk50(clk50), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .waitrequest(waitrequest),
    .vblank(vblank), .fb_address(fb_address), .fb_writedata(fb_writedata),
    .fb_write(fb_write), .busy(busy), .dbg_state(dbg_state)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a data write yields one word, a fill command yields the whole frame.
  task automatic model_push(input logic [14:0] a, input logic [31:0] d);
    if (int'(a) < FB_WORDS) exp_q.push_back({a, d});
    else if (a == 15'h7FFF)
      for (int i = 0; i < FB_WORDS; i++) exp_q.push_back({15'(i), d});
  endtask

  task automatic host_write(input logic [14:0] a, input logic [31:0] d);
    int  n;
    logic acc;
    n = 0;
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    forever begin
      acc = !waitrequest;
      @(posedge clk50);
      if (acc) begin model_push(a, d); break; end
      n++;
      if (n > 20000) begin chk("host_write_timeout", 1, 0); break; end
      @(negedge clk50);
    end
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk50);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk50);
      n++;
    end
    chk("drain_done_busy", busy, 0);
    chk("drain_done_exp_left", exp_q.size(), 0);
  endtask

  task automatic wait_fill_addr(input logic [14:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk50);
      n++;
    end while (!(fb_write && fb_address == a) && n < 20000);
    chk("reach_fill_addr", fb_address, a);
  endtask

  always @(negedge clk50) begin
    if (!reset && fb_write) begin
      n_writes++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", fb_address, fb_writedata);
      end else begin
        logic [46:0] e;
        e = exp_q.pop_front();
        if ({fb_address, fb_writedata} !== e) begin
          mismatched++;
          $display("FAIL fb_write_order: got addr %0h data %0h expected addr %0h data %0h",
                   fb_address, fb_writedata, e[46:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [14:0] a;
    logic [31:0] d;
    int r;
    bit fill_done;

    reset = 1'b1; chipselect = 1'b0; write = 1'b0; vblank = 1'b1;
    address = '0; writedata = '0;
    #5;
    chk("rst_fb_write", fb_write, 0);
    chk("rst_fb_address", fb_address, 0);
    chk("rst_fb_writedata", fb_writedata, 0);
    chk("rst_waitrequest", waitrequest, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk50);
    reset = 1'b0;

    // Single write latency: accepted at edge k, strobe between k+1 and k+2
    host_write(15'd5, 32'hDEADBEEF);
    @(negedge clk50);
    chk("lat_k0_fb_write", fb_write, 0);
    @(negedge clk50);
    chk("lat_k1_fb_write", fb_write, 1);
    chk("lat_k1_addr", fb_address, 5);
    chk("lat_k1_data", fb_writedata, 32'hDEADBEEF);
    @(negedge clk50);
    chk("lat_k2_fb_write", fb_write, 0);
    chk("hold_addr", fb_address, 5);
    chk("hold_data", fb_writedata, 32'hDEADBEEF);
    wait_idle(100);

    // Out-of-range writes are accepted and dropped
    @(negedge clk50); w = n_writes;
    host_write(15'd9600, 32'h11111111);
    host_write(15'h7FFE, 32'h22222222);
    repeat (5) @(negedge clk50);
    chk("discard_no_write", n_writes, w);
    chk("discard_busy", busy, 0);
    chk("discard_waitrequest", waitrequest, 0);

    // Fill then data: data held behind the fill until the queue is full
    host_write(15'h7FFF, 32'hFFFFFFFF);
    host_write(15'd3, 32'h0);
    for (int i = 0; i < DEPTH - 1; i++)
      host_write(15'($urandom_range(0, FB_WORDS - 1)), $urandom);
    @(negedge clk50);
    chk("full_waitrequest", waitrequest, 1);
    chk("full_busy", busy, 1);
    host_write(15'd77, 32'h12345678);
    wait_idle(12000);
    chk("after_fill_waitrequest", waitrequest, 0);

    // Reset in the middle of a fill
    host_write(15'h7FFF, 32'hA5A5A5A5);
    wait_fill_addr(15'd4000);
    #3 reset = 1'b1;
    #1;
    chk("midfill_rst_fb_write", fb_write, 0);
    chk("midfill_rst_fb_address", fb_address, 0);
    chk("midfill_rst_fb_writedata", fb_writedata, 0);
    chk("midfill_rst_busy", busy, 0);
    chk("midfill_rst_waitrequest", waitrequest, 0);
    exp_q.delete();
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50); w = n_writes;
    repeat (40) @(negedge clk50);
    chk("post_rst_no_write", n_writes, w);
    chk("post_rst_busy", busy, 0);

`ifdef FBQ_VBLANK_ONLY_EN
    // Gate closed: queue fills and stalls, then drains once vblank rises
    @(negedge clk50); vblank = 1'b0; w = n_writes;
    for (int i = 0; i < DEPTH; i++) host_write(15'(i * 7), 32'(i) ^ 32'hC0DE0000);
    @(negedge clk50);
    chk("vb_full_waitrequest", waitrequest, 1);
    repeat (20) @(negedge clk50);
    chk("vb_closed_no_write", n_writes, w);
    vblank = 1'b1;
    wait_idle(200);
    chk("vb_open_waitrequest", waitrequest, 0);

    // Gate closes mid-fill: fill address holds and resumes
    host_write(15'h7FFF, 32'h0F0F0F0F);
    wait_fill_addr(15'd99);
    vblank = 1'b0;
    @(negedge clk50); w = n_writes;
    repeat (30) @(negedge clk50);
    chk("vb_fill_paused", n_writes, w);
    vblank = 1'b1;
    wait_idle(12000);
`endif

    // Random traffic with one fill command in the middle
    fill_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (i == 75 && !fill_done) begin
        a = 15'h7FFF; fill_done = 1'b1;
      end else if (r == 8) a = 15'($urandom_range(FB_WORDS, 32766));
      else a = 15'($urandom_range(0, FB_WORDS - 1));
      host_write(a, d);
      vblank = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk50);
    end
    vblank = 1'b1;
    wait_idle(20000);
    chk("final_waitrequest", waitrequest, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fb_write_queue.md
FB_WRITE_QUEUE -- requirements
Module: fb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: queue entries; power of two, 4..64.
REQ-002 SHALL have parameter FB_WORDS, default 9600: framebuffer words (640x480 at 1 bpp, 32 pixels per word).
REQ-003 SHALL have port clk50, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port chipselect, input, 1: host select.
REQ-006 SHALL have port write, input, 1: host write strobe.
REQ-007 SHALL have port address, input, 15: host word address.
REQ-008 SHALL have port writedata, input, 32: host data.
REQ-009 SHALL have port waitrequest, output, 1: host stall.
REQ-010 SHALL have port vblank, input, 1: high while the display scans outside active rows (vcount >= 480).
REQ-011 SHALL have port fb_address, output, 15: framebuffer write address.
REQ-012 SHALL have port fb_writedata, output, 32: framebuffer write data.
REQ-013 SHALL have port fb_write, output, 1: framebuffer write enable, one word per cycle.
REQ-014 SHALL have port busy, output, 1: queue non-empty, FILL active, or fb_write high.

Function
REQ-015 SHALL accept a host write on a rising edge where chipselect & write & !waitrequest.
REQ-016 SHALL drive waitrequest = 1 exactly when the queue holds DEPTH entries; a pop in the same cycle does not clear it.
REQ-017 SHALL queue accepted writes with address < FB_WORDS as data entries, and with address 0x7FFF as fill entries (writedata = fill pattern).
REQ-018 SHALL accept and discard writes with FB_WORDS <= address <= 0x7FFE, with no queue entry.
REQ-019 SHALL implement an FSM with states IDLE, DRAIN and FILL.
REQ-020 IDLE -> DRAIN when the queue is non-empty and the drain gate is open (REQ-032/033).
REQ-021 DRAIN SHALL pop one entry per cycle while the gate is open; a data entry produces a registered fb_write pulse with its address and data in the following cycle.
REQ-022 DRAIN -> FILL when the popped entry is a fill entry; it produces no write of its own.
REQ-023 FILL SHALL write the pattern to addresses 0 .. FB_WORDS-1 in ascending order, one per cycle while the gate is open, then go to DRAIN if the queue is non-empty, else to IDLE.
REQ-024 DRAIN -> IDLE when the queue is empty or the gate closes.
REQ-025 With the gate open and an empty queue, a write accepted at edge k SHALL drive fb_write high exactly between edges k+1 and k+2.
REQ-026 Writes SHALL reach the framebuffer in acceptance order; a data entry queued after a fill entry SHALL be written after the whole fill.
REQ-027 Push and pop in the same cycle SHALL both occur with the occupancy unchanged; pointers wrap modulo DEPTH.
REQ-028 When the gate closes mid-FILL, the fill address SHALL hold and resume when the gate reopens; an in-flight registered write still completes.
REQ-029 fb_address and fb_writedata SHALL hold their last values when fb_write = 0.

Reset
REQ-030 On reset assertion, immediately and regardless of clock: queue empty, FSM = IDLE, fill address = 0, fb_write = 0, fb_address = 0, fb_writedata = 0, waitrequest = 0, busy = 0.
REQ-031 Reset during FILL or DRAIN SHALL abort the operation and discard all queued entries.

Configuration
REQ-032 With FBQ_VBLANK_ONLY_EN defined, the drain gate SHALL equal vblank, so framebuffer writes occur only during vertical blanking (tear-free).
REQ-033 Without FBQ_VBLANK_ONLY_EN, the drain gate SHALL be constantly open and vblank SHALL be ignored.

Verification
REQ-034 Macro off: write addr 5, data 0xDEADBEEF at edge k -> fb_write high for cycle k+1..k+2 with fb_address = 5, fb_writedata = 0xDEADBEEF.
REQ-035 Macro on, vblank = 0: 16 writes -> waitrequest = 1 after the 16th and fb_write stays 0; raise vblank -> 16 consecutive fb_write pulses in order; waitrequest = 0.
REQ-036 Write 0x7FFF = 0xFFFFFFFF, then addr 3 = 0 -> 9600 writes of 0xFFFFFFFF to addresses 0..9599, then one write addr 3 = 0; busy = 0 afterwards.
REQ-037 Write addr 9600 and addr 0x7FFE -> both accepted with no fb_write; queue stays empty.
REQ-038 Assert reset at fill address 4000 -> all outputs 0 immediately; no fb_write after release with no host traffic.
REQ-039 Macro on: drop vblank at fill address 100 -> no writes at or beyond address 100 until vblank rises, then resume at 100.
